// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter (double-dabble), one operand bit per
//   clock. A conversion is requested with start. It runs for BIN_W SHIFT cycles
//   and then one DONE cycle. In the DONE cycle done pulses, and bcd/overflow/sign
//   hold the new result until the next done.
//
//   Optional feature: define SIGNED_INPUT_EN to treat bin as two's complement.
//   The magnitude is converted and the sign is reported on sign. Without the
//   macro, sign is tied to 0 and no negation logic exists.
//
// Parameters
//   BIN_W   width of the binary operand (>= 2)
//   DIGITS  number of BCD digits produced; the ones digit is bcd[3:0]
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   conversion request; honoured only in IDLE or DONE
//   bin       in   operand, captured on the edge that accepts start
//   busy      out  high while shifting (exactly BIN_W cycles per conversion)
//   done      out  one-cycle pulse when bcd/overflow/sign are updated
//   bcd       out  packed BCD result (value mod 10^DIGITS)
//   overflow  out  result needs more than DIGITS digits
//   sign      out  operand was negative (SIGNED_INPUT_EN only, else 0)
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic                  sign
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [BIN_W-1:0]   operand_reg;
    logic [BCD_W-1:0]   digits_reg;
    logic               ovf_acc_reg;
    logic [CNT_W-1:0]   count_reg;

    logic               accept;
    logic               last_shift;
    logic [BIN_W-1:0]   operand_in;
    logic [BCD_W-1:0]   digits_adj;
    logic [BCD_W-1:0]   digits_next;
    logic               carry_out;
    logic               ovf_next;

    assign accept     = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_shift = (state_reg == SHIFT) && (count_reg == LAST_CNT);
    assign busy       = (state_reg == SHIFT);
    assign done       = (state_reg == DONE);

    // Add-3 correction for every digit that is 5 or more, ahead of the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign digits_adj[gi*4 +: 4] = (digits_reg[gi*4 +: 4] >= 4'd5)
                                         ? digits_reg[gi*4 +: 4] + 4'd3
                                         : digits_reg[gi*4 +: 4];
        end
    endgenerate

    // The bit that leaves the top digit lands in the guard position. It is
    // folded straight into the overflow accumulator. A top digit of 5 or more
    // becomes 8 or more after correction, so that case shows up here as well.
    assign {carry_out, digits_next} = {digits_adj, operand_reg[BIN_W-1]};
    assign ovf_next                 = ovf_acc_reg | carry_out;

`ifdef SIGNED_INPUT_EN
    logic sign_cap_reg;
    // Negation in BIN_W unsigned bits maps -2^(BIN_W-1) onto 2^(BIN_W-1).
    assign operand_in = bin[BIN_W-1] ? (~bin + 1'b1) : bin;
`else
    assign operand_in = bin;
    assign sign       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand_reg  <= '0;
            digits_reg   <= '0;
            ovf_acc_reg  <= 1'b0;
            count_reg    <= '0;
            bcd          <= '0;
            overflow     <= 1'b0;
`ifdef SIGNED_INPUT_EN
            sign_cap_reg <= 1'b0;
            sign         <= 1'b0;
`endif
        end else if (accept) begin
            operand_reg  <= operand_in;
            digits_reg   <= '0;
            ovf_acc_reg  <= 1'b0;
            count_reg    <= '0;
`ifdef SIGNED_INPUT_EN
            sign_cap_reg <= bin[BIN_W-1];
`endif
        end else if (state_reg == SHIFT) begin
            operand_reg <= operand_reg << 1;
            digits_reg  <= digits_next;
            ovf_acc_reg <= ovf_next;
            count_reg   <= count_reg + 1'b1;
            // Results are loaded on the edge that enters DONE, so they are
            // already valid while done is high.
            if (last_shift) begin
                bcd      <= digits_next;
                overflow <= ovf_next;
`ifdef SIGNED_INPUT_EN
                sign     <= sign_cap_reg;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;

    logic        busy_a, done_a, ovf_a, sign_a;
    logic [11:0] bcd_a;
    logic        busy_b, done_b, ovf_b, sign_b;
    logic [7:0]  bcd_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a), .sign(sign_a)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b), .sign(sign_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: decimal digits by integer division, sign/magnitude by arithmetic.
    function automatic void model(input logic [7:0] b, input int digits,
                                  output logic [11:0] bcd, output logic ovf,
                                  output logic sgn);
        int v;
        int p;
        sgn = 1'b0;
        v   = int'(b);
`ifdef SIGNED_INPUT_EN
        if (b[7]) begin
            sgn = 1'b1;
            v   = 256 - int'(b);
        end
`endif
        bcd = '0;
        p   = 1;
        for (int d = 0; d < digits; d++) begin
            bcd[d*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        ovf = (v >= p);
    endfunction

    // Called at a negedge. Requests conversion of v and waits for done.
    // hold keeps start high (back-to-back); inject pokes start/bin=37 mid-SHIFT.
    task automatic conv(input logic [7:0] v, input bit hold, input bit inject);
        logic [11:0] ea, eb;
        logic        oa, ob, sa, sb;
        int n;
        int nbusy;
        model(v, 3, ea, oa, sa);
        model(v, 2, eb, ob, sb);
        start = 1'b1;
        bin   = v;
        n     = 0;
        nbusy = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if (!hold) start = 1'b0;
                bin = 8'($urandom);
            end
            if (inject && n == 3) begin
                start = 1'b1;
                bin   = 8'd37;
            end
            if (inject && n == 4) start = 1'b0;
            if (busy_a) nbusy++;
            if (done_a) break;
        end
        chk("done_latency", n, BIN_W + 1);
        chk("busy_cycles", nbusy, BIN_W);
        chk("busy_in_done", busy_a, 1'b0);
        chk("done_b_aligned", done_b, 1'b1);
        chk("bcd3", bcd_a, ea);
        chk("ovf3", ovf_a, oa);
        chk("sign3", sign_a, sa);
        chk("bcd2", bcd_b, eb[7:0]);
        chk("ovf2", ovf_b, ob);
        chk("sign2", sign_b, sb);
        $display("conv bin=%0d hold=%0b bcd3=%03h ovf3=%0b bcd2=%02h ovf2=%0b sign=%0b",
                 v, hold, bcd_a, ovf_a, bcd_b, ovf_b, sign_a);
    endtask

    initial begin
        int pulses;
        logic [11:0] ea;
        logic        oa, sa;

        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_bcd", bcd_a, 12'h000);
        chk("rst_ovf", ovf_a, 1'b0);
        chk("rst_sign", sign_a, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner values, including the DIGITS=2 overflow boundary.
        conv(8'd255, 0, 0);
        conv(8'd0,   0, 0);
        conv(8'd99,  0, 0);
        model(8'd99, 3, ea, oa, sa);
        repeat (3) begin
            @(negedge clk);
            chk("hold_done_low", done_a, 1'b0);
            chk("hold_bcd", bcd_a, ea);
        end
        conv(8'd100, 0, 0);
        conv(8'h80,  0, 0);
        conv(8'hF6,  0, 0);

        // start during SHIFT must be ignored.
        conv(8'd200, 0, 1);
        model(8'd200, 3, ea, oa, sa);
        pulses = 0;
        repeat (BIN_W + 3) begin
            @(negedge clk);
            if (done_a) pulses++;
        end
        chk("no_extra_done", pulses, 0);
        chk("bcd_after_inject", bcd_a, ea);

        // Reset at SHIFT count 4 aborts the conversion.
        start = 1'b1;
        bin   = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", busy_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_bcd", bcd_a, 12'h000);
        chk("abort_ovf", ovf_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (BIN_W + 4) begin
            @(negedge clk);
            if (done_a) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        conv(8'd128, 0, 0);

        // Random operands.
        for (int i = 0; i < 20; i++) begin
            conv(8'($urandom_range(0, 255)), 0, 0);
        end

        // start held high: each conversion completes BIN_W+1 cycles apart.
        for (int j = 0; j < 6; j++) begin
            conv(8'($urandom), 1, 0);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_hold", busy_a, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
